// File: rtl/mmm_exp_ctrl.sv
// Sequencer for the Montgomery modular-exponentiation datapath: left-to-right square-and-multiply.
// Define MMM_SKIP_LEAD_ZERO_EN to skip SQR/MUL for exponent bits above the most significant 1.
module mmm_exp_ctrl #(
   parameter int WIDTH = 10,
   parameter int CW    = 4
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] exp_i,
   output logic             mmm_rst_n,
   output logic             mmm_en,
   output logic             mmm_ld_a,
   output logic [2:0]       op_sel,
   output logic             wr_en,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLR   = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_STORE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_ABORT = 3'd6;

   localparam logic [2:0] OP_PRE_M = 3'd0;
   localparam logic [2:0] OP_PRE_X = 3'd1;
   localparam logic [2:0] OP_SQR   = 3'd2;
   localparam logic [2:0] OP_MUL   = 3'd3;
   localparam logic [2:0] OP_POST  = 3'd4;

   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] IDX_TOP  = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [2:0]       state, state_n;
   logic [2:0]       op, op_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [CW-1:0]    idx, idx_n;
   logic [WIDTH-1:0] exp_q, exp_n;
   logic             in_op;

`ifdef MMM_SKIP_LEAD_ZERO_EN
   function automatic logic [CW-1:0] msb_idx(input logic [WIDTH-1:0] e);
      msb_idx = '0;
      for (int i = 0; i < WIDTH; i++)
         if (e[i]) msb_idx = CW'(i);
   endfunction
`endif

   assign in_op  = (state == S_CLR) || (state == S_LOAD) || (state == S_RUN) || (state == S_STORE);
   assign op_sel = op;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_n = state;
      op_n    = op;
      cnt_n   = cnt;
      idx_n   = idx;
      exp_n   = exp_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_CLR;
               op_n    = OP_PRE_M;
               idx_n   = IDX_TOP;
               exp_n   = exp_i;
            end
         end
         S_CLR:  state_n = S_LOAD;
         S_LOAD: begin
            state_n = S_RUN;
            cnt_n   = '0;
         end
         S_RUN: begin
            if (cnt == CNT_LAST) state_n = S_STORE;
            else                 cnt_n   = cnt + ONE;
         end
         S_STORE: begin
            state_n = S_CLR;
            case (op)
               OP_PRE_M: op_n = OP_PRE_X;
               OP_PRE_X: begin
`ifdef MMM_SKIP_LEAD_ZERO_EN
                  // Above the leading 1, X stays R mod n, so those squarings are identities.
                  if (exp_q == '0) begin
                     op_n = OP_POST;
                  end else begin
                     op_n  = OP_SQR;
                     idx_n = msb_idx(exp_q);
                  end
`else
                  op_n = OP_SQR;
`endif
               end
               OP_SQR: begin
                  if (exp_q[idx]) begin
                     op_n = OP_MUL;
                  end else if (idx == '0) begin
                     op_n = OP_POST;
                  end else begin
                     op_n  = OP_SQR;
                     idx_n = idx - ONE;
                  end
               end
               OP_MUL: begin
                  if (idx == '0) begin
                     op_n = OP_POST;
                  end else begin
                     op_n  = OP_SQR;
                     idx_n = idx - ONE;
                  end
               end
               default: state_n = S_DONE;
            endcase
         end
         S_DONE:  state_n = S_IDLE;
         S_ABORT: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (abort && in_op) state_n = S_ABORT;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= S_IDLE;
         op    <= OP_PRE_M;
         cnt   <= '0;
         idx   <= '0;
         exp_q <= '0;
      end else begin
         state <= state_n;
         op    <= op_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         exp_q <= exp_n;
      end
   end

   // Outputs are registered decodes of the next state, so reset can hold mmm_rst_n low.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         mmm_rst_n <= 1'b0;
         mmm_en    <= 1'b0;
         mmm_ld_a  <= 1'b0;
         wr_en     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         mmm_rst_n <= !((state_n == S_CLR) || (state_n == S_ABORT));
         mmm_en    <= (state_n == S_LOAD) || (state_n == S_RUN);
         mmm_ld_a  <= (state_n == S_LOAD);
         wr_en     <= (state_n == S_STORE);
         busy      <= (state_n == S_CLR) || (state_n == S_LOAD) ||
                      (state_n == S_RUN) || (state_n == S_STORE);
         done      <= (state_n == S_DONE);
      end
   end

endmodule

// File: tb/tb_mmm_exp_ctrl.sv
// Self-checking bench for mmm_exp_ctrl: per-cycle outputs compared with an op-list reference model.
module tb_mmm_exp_ctrl;

   localparam int W     = 10;
   localparam int CW    = 4;
   localparam int OPLEN = W + 3;

   logic         clk = 1'b0;
   logic         rstb;
   logic         start;
   logic         abort;
   logic [W-1:0] exp_i;
   logic         mmm_rst_n, mmm_en, mmm_ld_a, wr_en, busy, done;
   logic [2:0]   op_sel;

   int tests = 0;
   int fails = 0;
   int ops[$];

   mmm_exp_ctrl #(.WIDTH(W), .CW(CW)) dut (
      .clk       (clk),
      .rstb      (rstb),
      .start     (start),
      .abort     (abort),
      .exp_i     (exp_i),
      .mmm_rst_n (mmm_rst_n),
      .mmm_en    (mmm_en),
      .mmm_ld_a  (mmm_ld_a),
      .op_sel    (op_sel),
      .wr_en     (wr_en),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // {mmm_rst_n, mmm_en, mmm_ld_a, wr_en, busy, done}
   function automatic logic [5:0] ctrl();
      return {mmm_rst_n, mmm_en, mmm_ld_a, wr_en, busy, done};
   endfunction

   // Reference op list: PRE_M, PRE_X, per bit SQR (+MUL on a 1), POST.
   task automatic build_ops(input logic [W-1:0] e);
      int top;
      ops.delete();
      ops.push_back(0);
      ops.push_back(1);
      top = W - 1;
`ifdef MMM_SKIP_LEAD_ZERO_EN
      top = -1;
      for (int i = 0; i < W; i++) if (e[i]) top = i;
`endif
      for (int i = top; i >= 0; i--) begin
         ops.push_back(2);
         if (e[i]) ops.push_back(3);
      end
      ops.push_back(4);
   endtask

   task automatic run_exp(input logic [W-1:0] e, input int abort_c, input int restart_c,
                          input logic [W-1:0] e_alt, input bit scramble, input bit both,
                          output int done_at, output int wr_cnt);
      int n, total, p, done_cnt;
      logic [5:0] ev;
      bit ab;
      build_ops(e);
      n     = ops.size();
      total = n * OPLEN + 1;
      ab    = (abort_c > 0) && (abort_c < total);
      @(negedge clk);
      start = 1'b1;
      exp_i = e;
      abort = both;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (scramble) exp_i = W'($urandom);
      done_at  = -1;
      wr_cnt   = 0;
      done_cnt = 0;
      for (int c = 1; c <= total + 1; c++) begin
         if (ab && c == abort_c + 1) begin
            ev = 6'b000000;
         end else if (ab && c == abort_c + 2) begin
            ev = 6'b100000;
         end else if (c < total) begin
            p  = (c - 1) % OPLEN;
            ev = (p == 0) ? 6'b000010 :
                 (p == 1) ? 6'b111010 :
                 (p == OPLEN - 1) ? 6'b100110 : 6'b110010;
            check($sformatf("op_sel e=%0h c=%0d", e, c), 32'(op_sel), 32'(ops[(c - 1) / OPLEN]));
         end else if (c == total) begin
            ev = 6'b100001;
         end else begin
            ev = 6'b100000;
         end
         check($sformatf("ctrl e=%0h c=%0d", e, c), 32'(ctrl()), 32'(ev));
         if (wr_en) wr_cnt++;
         if (done) begin
            done_cnt++;
            done_at = c;
         end
         if (ab && c == abort_c + 2) break;
         start = 1'b0;
         abort = 1'b0;
         if (c == restart_c) begin
            start = 1'b1;
            exp_i = e_alt;
         end
         if (c == abort_c) abort = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
      check($sformatf("done pulses e=%0h", e), 32'(done_cnt), ab ? 32'd0 : 32'd1);
   endtask

   initial begin
      int d, w, k, c_ab, mode, n;
      logic [W-1:0] e;
      rstb  = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      exp_i = '0;
      #12;
      check("reset values", 32'({ctrl(), op_sel}), 32'd0);
      @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);
      check("idle after reset", 32'(ctrl()), 32'(6'b100000));

      // Directed exponent 3
      run_exp(10'b0000000011, 0, 0, '0, 1'b0, 1'b0, d, w);
`ifdef MMM_SKIP_LEAD_ZERO_EN
      check("E=3 latency", 32'(d), 32'd92);
      check("E=3 wr_en count", 32'(w), 32'd7);
`else
      check("E=3 latency", 32'(d), 32'd196);
      check("E=3 wr_en count", 32'(w), 32'd15);
`endif

      // Exponent zero
      run_exp('0, 0, 0, '0, 1'b0, 1'b0, d, w);
      check("E=0 wr_en count", 32'(w), 32'(ops.size()));

      // Abort during the 3rd SQR's RUN, then a fresh start
      e = 10'b1010011010;
      build_ops(e);
      k = 0;
      c_ab = 0;
      foreach (ops[i]) if (ops[i] == 2) begin
         k++;
         if (k == 3 && c_ab == 0) c_ab = i * OPLEN + 5;
      end
      run_exp(e, c_ab, 0, '0, 1'b0, 1'b0, d, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("quiet after abort", 32'(ctrl()), 32'(6'b100000));
      end
      run_exp(10'b0110110001, 0, 0, '0, 1'b0, 1'b0, d, w);
      check("wr_en count after abort", 32'(w), 32'(ops.size()));

      // Restart while busy with a different exponent, plus exp_i scrambling
      run_exp(10'b1100101011, 0, 20, 10'b0011010100, 1'b1, 1'b0, d, w);

      // start and abort together in IDLE: start wins
      run_exp(10'b0000101101, 0, 0, '0, 1'b0, 1'b1, d, w);

      // abort during DONE has no effect
      build_ops(10'b0100000001);
      run_exp(10'b0100000001, ops.size() * OPLEN + 1, 0, '0, 1'b0, 1'b0, d, w);

      // Reset during the 5th RUN cycle of PRE_M
      @(negedge clk);
      start = 1'b1;
      exp_i = W'($urandom);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("5th RUN cycle", 32'(ctrl()), 32'(6'b110010));
      #1 rstb = 1'b0;
      #1 check("async reset mid-RUN", 32'({ctrl(), op_sel}), 32'd0);
      @(negedge clk);
      rstb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("idle after mid-RUN reset", 32'(ctrl()), 32'(6'b100000));
      end

      // Randomized runs
      for (int r = 0; r < 12; r++) begin
         e    = W'($urandom);
         mode = $urandom_range(0, 3);
         build_ops(e);
         n = ops.size() * OPLEN;
         case (mode)
            1:       run_exp(e, 0, 0, '0, 1'b1, 1'b0, d, w);
            2:       run_exp(e, 0, $urandom_range(1, n), W'($urandom), 1'b1, 1'b0, d, w);
            3:       run_exp(e, $urandom_range(1, n), 0, '0, 1'b0, 1'b0, d, w);
            default: run_exp(e, 0, 0, '0, 1'b0, 1'b0, d, w);
         endcase
         if (mode != 3) check($sformatf("latency e=%0h", e), 32'(d), 32'(n + 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mmm_exp_ctrl.md
Name: mmm_exp_ctrl

Overview:
- Sequencer for the RSA modular-exponentiation datapath.
- Drives one Montgomery multiplier (MMM) core and its serial A-operand shift register: enable, load, clear, operand selection and write-back.
- Schedules left-to-right square-and-multiply over a WIDTH-bit exponent, including Montgomery pre- and post-conversion.
- Sits between the top-level register interface (start/exponent) and the MMM datapath.

Parameters:
- WIDTH, 10, operand/exponent width; also the number of serial bit cycles per MMM operation.
- CW, 4, width of the bit counter; must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  system clock.
- rstb  in  1  reset; asynchronous, active-low.
- start  in  1  begin exponentiation; sampled only in IDLE.
- abort  in  1  synchronous cancel of a running exponentiation.
- exp_i  in  WIDTH  exponent E; latched when start is accepted.
- mmm_rst_n  out  1  active-low clear to the MMM core and shift register (drives rst_mmm_i).
- mmm_en  out  1  datapath enable.
- mmm_ld_a  out  1  shift-register parallel load.
- op_sel  out  3  operand-pair select: 0 PRE_M (A=M, B=R2, dest MB); 1 PRE_X (A=1, B=R2, dest X); 2 SQR (A=X, B=X, dest X); 3 MUL (A=MB, B=X, dest X); 4 POST (A=X, B=1, dest X).
- wr_en  out  1  one-cycle write-back strobe for the op_sel destination.
- busy  out  1  high from the cycle after start is accepted through the last STORE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values (async, rstb low): state IDLE, mmm_rst_n=0, mmm_en=0, mmm_ld_a=0, op_sel=0, wr_en=0, busy=0, done=0, all counters 0.
- In IDLE: mmm_rst_n=1.
- Per-op micro-sequence, WIDTH+3 cycles; op_sel stable for the whole op:
  - CLR, 1 cycle: mmm_rst_n=0.
  - LOAD, 1 cycle: mmm_en=1, mmm_ld_a=1.
  - RUN, WIDTH cycles: mmm_en=1, mmm_ld_a=0. The register presents A[0]..A[WIDTH-1] in order.
  - STORE, 1 cycle: mmm_en=0, wr_en=1.
- Exponent scheduler:
  - start=1 in IDLE at edge k: latch E, set bit index i=WIDTH-1; CLR of PRE_M occurs in cycle k+1.
  - Op order: PRE_M, PRE_X, then for i=WIDTH-1 down to 0: SQR, then MUL only if E[i]=1; then POST.
  - After the STORE of POST: state DONE for 1 cycle (done=1, busy=0), then IDLE.
  - Latency, start edge to done cycle: ops*(WIDTH+3)+1.
- Bit index decrements after each bit's last op (SQR, or MUL when E[i]=1); wraps from 0 to POST. No underflow.
- start while busy: ignored; the latched exponent is unchanged.
- Changes on exp_i after acceptance: no effect.
- abort=1 while busy, at any state (including during RUN):
  - next cycle is CLR-like: mmm_rst_n=0, wr_en=0, no done pulse; then IDLE.
  - abort in IDLE or DONE: no effect. The DONE pulse still occurs.
- start and abort high together in IDLE: start wins; abort is ignored that cycle.
- rstb low mid-operation: immediate return to reset values; no write-back.
- E=0: PRE_M, PRE_X, WIDTH×SQR, POST (without the option). Result register holds 1 mod n.

Optional Feature:
- Macro: MMM_SKIP_LEAD_ZERO_EN.
- Defined: SQR and MUL are skipped for all exponent bits above the most significant 1.
  - X equals R mod n there, so squaring is an identity in the Montgomery domain.
  - E=0 yields PRE_M, PRE_X, POST only.
- Undefined: all WIDTH bits are processed, giving a fixed op count per Hamming weight.

Test Plan:
- Reset mid-RUN: assert rstb low during the 5th RUN cycle -> all outputs at reset values within the same cycle; after release, IDLE with mmm_rst_n=1; no wr_en.
- E=10'b0000000011, WIDTH=10, no option: 15 ops (PRE_M, PRE_X, 10 SQR, MUL at bits 1 and 0, POST) -> op_sel trace 0,1,2×8,2,3,2,3,4; done exactly 196 cycles after the start edge; 15 wr_en pulses.
- E=10'b0000000011 with MMM_SKIP_LEAD_ZERO_EN: op_sel trace 0,1,2,3,2,3,4 -> done 92 cycles after the start edge.
- Single-op timing: per op exactly 1 CLR, 1 LOAD (ld_a=1), 10 RUN (en=1, ld_a=0), 1 STORE (wr_en=1); en never high in CLR or STORE.
- abort asserted in the 3rd SQR's RUN -> next cycle mmm_rst_n=0, then IDLE; busy=0, no done, no further wr_en. A new start then succeeds normally.
- start re-pulsed while busy with a different exp_i -> op trace identical to the original exponent; exactly one done pulse.
